// File: rtl/reflet_mem_arbiter.sv
// reflet_mem_arbiter: two-master round-robin arbiter in front of a single
// synchronous-read memory. Each access is granted in an IDLE cycle, then
// held in ACCESS for `latency` cycles, the last of which carries the
// one-cycle ack and, for reads, the memory data.
module reflet_mem_arbiter #(
    parameter int wordsize = 16,
    parameter int latency  = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req0,
    input  logic                req1,
    input  logic [wordsize-1:0] addr0,
    input  logic [wordsize-1:0] addr1,
    input  logic [wordsize-1:0] wdata0,
    input  logic [wordsize-1:0] wdata1,
    input  logic                we0,
    input  logic                we1,
    output logic [wordsize-1:0] rdata0,
    output logic [wordsize-1:0] rdata1,
    output logic                ack0,
    output logic                ack1,
    output logic                mem_enable,
    output logic [wordsize-1:0] mem_addr,
    output logic [wordsize-1:0] mem_data_out,
    output logic                mem_write_en,
    input  logic [wordsize-1:0] mem_data_in,
    output logic                busy,
    output logic                owner
);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    // Wait-counter load value: ACCESS lasts `latency` cycles, ack on the last.
    localparam logic [3:0] CNT_INIT = 4'(latency - 1);

    state_t     state, state_next;
    logic       last, last_next;
    logic       owner_q, owner_next;
    logic       we_q, we_next;
    logic [3:0] cnt, cnt_next;

    logic       any_req;
    logic       grant_sel;

    // Grantee choice in IDLE: a lone requester wins; on a tie the one that
    // was not served last wins.
    always_comb begin
        any_req   = req0 | req1;
        grant_sel = (req0 && req1) ? ~last : req1;
    end

    // State, priority, owner and wait-counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            last    <= 1'b1;
            owner_q <= 1'b0;
            we_q    <= 1'b0;
            cnt     <= '0;
        end else begin
            state   <= state_next;
            last    <= last_next;
            owner_q <= owner_next;
            we_q    <= we_next;
            cnt     <= cnt_next;
        end
    end

    // Next-state logic plus memory-side muxing, acks and read data return.
    always_comb begin
        state_next   = state;
        last_next    = last;
        owner_next   = owner_q;
        we_next      = we_q;
        cnt_next     = cnt;
        mem_enable   = 1'b0;
        mem_addr     = '0;
        mem_data_out = '0;
        mem_write_en = 1'b0;
        ack0         = 1'b0;
        ack1         = 1'b0;
        rdata0       = '0;
        rdata1       = '0;
        busy         = 1'b0;

        case (state)
            IDLE: begin
                if (any_req) begin
                    mem_enable   = 1'b1;
                    mem_addr     = grant_sel ? addr1  : addr0;
                    mem_data_out = grant_sel ? wdata1 : wdata0;
                    mem_write_en = grant_sel ? we1    : we0;
                    owner_next   = grant_sel;
                    last_next    = grant_sel;
                    we_next      = grant_sel ? we1 : we0;
                    cnt_next     = CNT_INIT;
                    state_next   = ACCESS;
                end
            end

            ACCESS: begin
                busy         = 1'b1;
                mem_enable   = 1'b1;
                mem_addr     = owner_q ? addr1  : addr0;
                mem_data_out = owner_q ? wdata1 : wdata0;
                // The write strobe was issued in the grant cycle only.
                mem_write_en = 1'b0;
                if (cnt != '0) begin
                    cnt_next = cnt - 4'd1;
                end else begin
                    state_next = IDLE;
                    // Direction latched at grant so a write never returns data,
                    // even if the master misbehaves and drops its fields.
                    if (owner_q) begin
                        ack1   = 1'b1;
                        rdata1 = we_q ? '0 : mem_data_in;
                    end else begin
                        ack0   = 1'b1;
                        rdata0 = we_q ? '0 : mem_data_in;
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Owner is the registered grantee, visible from the cycle after grant.
    always_comb begin
        owner = owner_q;
    end

endmodule

// File: tb/tb_reflet_mem_arbiter.sv
// Testbench for reflet_mem_arbiter: two instances (latency 1 and 3), each
// with a small synchronous-read RAM; directed table, hand sequences and a
// randomized two-master run checked against a transaction-level model.
module tb_reflet_mem_arbiter;

    logic        clk;
    logic        rst          [2];
    logic        req0         [2];
    logic        req1         [2];
    logic        we0          [2];
    logic        we1          [2];
    logic [15:0] addr0        [2];
    logic [15:0] addr1        [2];
    logic [15:0] wdata0       [2];
    logic [15:0] wdata1       [2];
    logic [15:0] rdata0       [2];
    logic [15:0] rdata1       [2];
    logic [15:0] mem_addr     [2];
    logic [15:0] mem_data_out [2];
    logic [15:0] mem_data_in  [2];
    logic        ack0         [2];
    logic        ack1         [2];
    logic        mem_enable   [2];
    logic        mem_write_en [2];
    logic        busy         [2];
    logic        owner        [2];
    logic        pl_en        [2];
    logic [7:0]  pl_addr;
    logic [15:0] pl_data;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        r0, r1, w0, w1;
        logic [15:0] a0, a1, d0, d1;
        logic        e_en;
        logic [15:0] e_addr, e_dout;
        logic        e_we, e_ack0, e_ack1;
        logic [15:0] e_rd0, e_rd1;
        logic        e_busy, e_own;
    } vec_t;

    vec_t tbl [13];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar i = 0; i < 2; i++) begin : g_inst
        logic [15:0] ram [256];

        reflet_mem_arbiter #(.wordsize(16), .latency(i == 0 ? 1 : 3)) dut (
            .clk          (clk),
            .reset        (rst[i]),
            .req0         (req0[i]),
            .req1         (req1[i]),
            .addr0        (addr0[i]),
            .addr1        (addr1[i]),
            .wdata0       (wdata0[i]),
            .wdata1       (wdata1[i]),
            .we0          (we0[i]),
            .we1          (we1[i]),
            .rdata0       (rdata0[i]),
            .rdata1       (rdata1[i]),
            .ack0         (ack0[i]),
            .ack1         (ack1[i]),
            .mem_enable   (mem_enable[i]),
            .mem_addr     (mem_addr[i]),
            .mem_data_out (mem_data_out[i]),
            .mem_write_en (mem_write_en[i]),
            .mem_data_in  (mem_data_in[i]),
            .busy         (busy[i]),
            .owner        (owner[i])
        );

        // Synchronous-read RAM with a preload port for the bench.
        always @(posedge clk) begin
            if (pl_en[i]) begin
                ram[pl_addr] <= pl_data;
            end else if (mem_enable[i]) begin
                if (mem_write_en[i]) ram[mem_addr[i][7:0]] <= mem_data_out[i];
                mem_data_in[i] <= ram[mem_addr[i][7:0]];
            end
        end
    end

    task automatic chk1(string name, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0b want %0b", name, act, exp);
        end
    endtask

    task automatic chk16(string name, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %04h want %04h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(int d, logic r0, logic r1, logic w0, logic w1,
                         logic [15:0] a0, logic [15:0] a1,
                         logic [15:0] d0, logic [15:0] d1);
        req0[d]   = r0;
        req1[d]   = r1;
        we0[d]    = w0;
        we1[d]    = w1;
        addr0[d]  = a0;
        addr1[d]  = a1;
        wdata0[d] = d0;
        wdata1[d] = d1;
    endtask

    task automatic expect_all(int d, string tag, logic en, logic [15:0] addr,
                              logic [15:0] dout, logic we, logic a0, logic a1,
                              logic [15:0] r0, logic [15:0] r1, logic b, logic o);
        chk1 ({tag, "_mem_enable"},   mem_enable[d],   en);
        chk16({tag, "_mem_addr"},     mem_addr[d],     addr);
        chk16({tag, "_mem_data_out"}, mem_data_out[d], dout);
        chk1 ({tag, "_mem_write_en"}, mem_write_en[d], we);
        chk1 ({tag, "_ack0"},         ack0[d],         a0);
        chk1 ({tag, "_ack1"},         ack1[d],         a1);
        chk16({tag, "_rdata0"},       rdata0[d],       r0);
        chk16({tag, "_rdata1"},       rdata1[d],       r1);
        chk1 ({tag, "_busy"},         busy[d],         b);
        chk1 ({tag, "_owner"},        owner[d],        o);
    endtask

    task automatic do_reset(int d);
        drive(d, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
        rst[d] = 1'b1;
        tick();
        tick();
        rst[d] = 1'b0;
    endtask

    task automatic preload(int d, logic [7:0] a, logic [15:0] v);
        pl_en[d] = 1'b1;
        pl_addr  = a;
        pl_data  = v;
        tick();
        pl_en[d] = 1'b0;
    endtask

    // Transaction-level model: each grant occupies the memory from cycle N
    // to N+lat inclusive; data is a shadow array updated at write grants.
    task automatic run_random(int d, int ncyc);
        int          lat     = (d == 0) ? 1 : 3;
        int          free_at = 0;
        int          ack_at  = -1;
        logic        m_last  = 1'b1;
        logic        m_owner = 1'b0;
        logic        pend    = 1'b0;
        logic        g;
        logic [15:0] exp_rd  = '0;
        logic [15:0] shadow [8];
        logic        active [2];
        logic        ack_seen [2];
        logic        m_we [2];
        logic [15:0] m_addr [2];
        logic [15:0] m_wd [2];
        string       tag;

        rst[d] = 1'b1;
        for (int j = 0; j < 8; j++) begin
            shadow[j] = 16'($urandom);
            preload(d, 8'(j), shadow[j]);
        end
        for (int m = 0; m < 2; m++) begin
            active[m]   = 1'b0;
            ack_seen[m] = 1'b0;
            m_we[m]     = 1'b0;
            m_addr[m]   = '0;
            m_wd[m]     = '0;
        end
        do_reset(d);

        for (int cyc = 0; cyc < ncyc; cyc++) begin
            for (int m = 0; m < 2; m++) begin
                if (ack_seen[m]) active[m] = 1'b0;
                if (!active[m] && $urandom_range(0, 2) != 0) begin
                    active[m] = 1'b1;
                    m_addr[m] = 16'h8000 | 16'($urandom_range(0, 7));
                    m_we[m]   = 1'($urandom_range(0, 1));
                    m_wd[m]   = 16'($urandom);
                end
            end
            drive(d, active[0], active[1], m_we[0], m_we[1],
                  m_addr[0], m_addr[1], m_wd[0], m_wd[1]);
            @(negedge clk);
            tag = $sformatf("rnd%0d_c%0d", d, cyc);
            chk1({tag, "_owner"}, owner[d], m_owner);
            if (cyc >= free_at) begin
                chk1 ({tag, "_busy"},   busy[d],   1'b0);
                chk1 ({tag, "_ack0"},   ack0[d],   1'b0);
                chk1 ({tag, "_ack1"},   ack1[d],   1'b0);
                chk16({tag, "_rdata0"}, rdata0[d], 16'h0);
                chk16({tag, "_rdata1"}, rdata1[d], 16'h0);
                if (active[0] || active[1]) begin
                    g = (active[0] && active[1]) ? ~m_last : active[1];
                    chk1 ({tag, "_grant_en"},   mem_enable[d],   1'b1);
                    chk16({tag, "_grant_addr"}, mem_addr[d],     m_addr[g]);
                    chk16({tag, "_grant_dout"}, mem_data_out[d], m_wd[g]);
                    chk1 ({tag, "_grant_we"},   mem_write_en[d], m_we[g]);
                    if (m_we[g]) begin
                        shadow[m_addr[g][2:0]] = m_wd[g];
                        exp_rd = '0;
                    end else begin
                        exp_rd = shadow[m_addr[g][2:0]];
                    end
                    pend    = g;
                    m_last  = g;
                    m_owner = g;
                    ack_at  = cyc + lat;
                    free_at = ack_at + 1;
                end else begin
                    chk1 ({tag, "_idle_en"},   mem_enable[d],   1'b0);
                    chk16({tag, "_idle_addr"}, mem_addr[d],     16'h0);
                    chk16({tag, "_idle_dout"}, mem_data_out[d], 16'h0);
                    chk1 ({tag, "_idle_we"},   mem_write_en[d], 1'b0);
                end
            end else begin
                chk1 ({tag, "_acc_busy"}, busy[d],         1'b1);
                chk1 ({tag, "_acc_en"},   mem_enable[d],   1'b1);
                chk1 ({tag, "_acc_we"},   mem_write_en[d], 1'b0);
                chk16({tag, "_acc_addr"}, mem_addr[d],     m_addr[pend]);
                chk1 ({tag, "_acc_ack0"}, ack0[d], (cyc == ack_at) && !pend);
                chk1 ({tag, "_acc_ack1"}, ack1[d], (cyc == ack_at) && pend);
                chk16({tag, "_acc_rdata0"}, rdata0[d],
                      ((cyc == ack_at) && !pend) ? exp_rd : 16'h0);
                chk16({tag, "_acc_rdata1"}, rdata1[d],
                      ((cyc == ack_at) && pend) ? exp_rd : 16'h0);
            end
            ack_seen[0] = ack0[d];
            ack_seen[1] = ack1[d];
            tick();
        end
        drive(d, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
        rst[d] = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Cycle-by-cycle table for the latency-1 instance, from reset release.
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h8010, 16'h8002, 16'h0, 16'h0,
                    1'b1, 16'h8010, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h8010, 16'h8002, 16'h0, 16'h0,
                    1'b1, 16'h8010, 16'h0, 1'b0, 1'b1, 1'b0, 16'hBEEF, 16'h0, 1'b1, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h8010, 16'h8002, 16'h0, 16'h0,
                    1'b1, 16'h8002, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h8010, 16'h8002, 16'h0, 16'h0,
                    1'b1, 16'h8002, 16'h0, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0A0A, 1'b1, 1'b1};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h8010, 16'h8002, 16'h0, 16'h0,
                    1'b1, 16'h8010, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h8010, 16'h8002, 16'h0, 16'h0,
                    1'b1, 16'h8010, 16'h0, 1'b0, 1'b1, 1'b0, 16'hBEEF, 16'h0, 1'b1, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h8010, 16'h8002, 16'h0, 16'h0,
                    1'b1, 16'h8002, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h8010, 16'h8002, 16'h0, 16'h0,
                    1'b1, 16'h8002, 16'h0, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0A0A, 1'b1, 1'b1};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h8010, 16'h8002, 16'h0, 16'h1234,
                    1'b1, 16'h8002, 16'h1234, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h8010, 16'h8002, 16'h0, 16'h1234,
                    1'b1, 16'h8002, 16'h1234, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0, 1'b1, 1'b1};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h8010, 16'h8002, 16'h0, 16'h1234,
                    1'b1, 16'h8002, 16'h1234, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h8010, 16'h8002, 16'h0, 16'h1234,
                    1'b1, 16'h8002, 16'h1234, 1'b0, 1'b0, 1'b1, 16'h0, 16'h1234, 1'b1, 1'b1};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0,
                    1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1};

        pl_addr = '0;
        pl_data = '0;
        for (int d = 0; d < 2; d++) begin
            rst[d]   = 1'b1;
            pl_en[d] = 1'b0;
            drive(d, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
        end
        tick();
        preload(0, 8'h10, 16'hBEEF);
        preload(0, 8'h02, 16'h0A0A);
        preload(1, 8'h10, 16'hBEEF);
        preload(1, 8'h04, 16'hC0DE);

        // Reset values, then an idle bus for 20 cycles.
        do_reset(0);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            expect_all(0, $sformatf("idle%0d", c), 1'b0, 16'h0, 16'h0, 1'b0,
                       1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
            tick();
        end

        // Single read, latency 1.
        drive(0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h8010, 16'h0, 16'h0, 16'h0);
        @(negedge clk);
        expect_all(0, "sr_grant", 1'b1, 16'h8010, 16'h0, 1'b0,
                   1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        tick();
        @(negedge clk);
        expect_all(0, "sr_ack", 1'b1, 16'h8010, 16'h0, 1'b0,
                   1'b1, 1'b0, 16'hBEEF, 16'h0, 1'b1, 1'b0);
        tick();
        drive(0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
        @(negedge clk);
        expect_all(0, "sr_after", 1'b0, 16'h0, 16'h0, 1'b0,
                   1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        tick();

        // Simultaneous requests, then write-then-read by master 1.
        do_reset(0);
        for (int k = 0; k < 13; k++) begin
            drive(0, tbl[k].r0, tbl[k].r1, tbl[k].w0, tbl[k].w1,
                  tbl[k].a0, tbl[k].a1, tbl[k].d0, tbl[k].d1);
            @(negedge clk);
            expect_all(0, $sformatf("tbl%0d", k), tbl[k].e_en, tbl[k].e_addr,
                       tbl[k].e_dout, tbl[k].e_we, tbl[k].e_ack0, tbl[k].e_ack1,
                       tbl[k].e_rd0, tbl[k].e_rd1, tbl[k].e_busy, tbl[k].e_own);
            tick();
        end
        rst[0] = 1'b1;

        // Latency 3: single read.
        do_reset(1);
        @(negedge clk);
        expect_all(1, "l3_reset", 1'b0, 16'h0, 16'h0, 1'b0,
                   1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        tick();
        drive(1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h8010, 16'h0, 16'h0, 16'h0);
        @(negedge clk);
        expect_all(1, "l3_grant", 1'b1, 16'h8010, 16'h0, 1'b0,
                   1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            tick();
            @(negedge clk);
            expect_all(1, $sformatf("l3_acc%0d", k), 1'b1, 16'h8010, 16'h0, 1'b0,
                       k == 3, 1'b0, (k == 3) ? 16'hBEEF : 16'h0, 16'h0, 1'b1, 1'b0);
        end
        tick();
        drive(1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
        @(negedge clk);
        expect_all(1, "l3_after", 1'b0, 16'h0, 16'h0, 1'b0,
                   1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        tick();

        // Reset one cycle after a grant to master 1; access abandoned.
        drive(1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h8010, 16'h8004, 16'h0, 16'h0);
        @(negedge clk);
        expect_all(1, "rm_grant", 1'b1, 16'h8004, 16'h0, 1'b0,
                   1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        tick();
        rst[1] = 1'b1;
        @(negedge clk);
        chk1("rm_during_ack1", ack1[1], 1'b0);
        chk1("rm_during_busy", busy[1], 1'b1);
        tick();
        rst[1] = 1'b0;
        drive(1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            expect_all(1, $sformatf("rm_post%0d", c), 1'b0, 16'h0, 16'h0, 1'b0,
                       1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
            tick();
        end
        drive(1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h8010, 16'h8004, 16'h0, 16'h0);
        @(negedge clk);
        expect_all(1, "rm_regrant", 1'b1, 16'h8010, 16'h0, 1'b0,
                   1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            tick();
            @(negedge clk);
            expect_all(1, $sformatf("rm_acc%0d", k), 1'b1, 16'h8010, 16'h0, 1'b0,
                       k == 3, 1'b0, (k == 3) ? 16'hBEEF : 16'h0, 16'h0, 1'b1, 1'b0);
        end
        tick();
        drive(1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
        rst[1] = 1'b1;
        tick();

        // Randomized two-master traffic on both latencies.
        run_random(0, 400);
        run_random(1, 400);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reflet_mem_arbiter.md
# reflet_mem_arbiter

Two-requester round-robin arbiter that shares one synchronous-read memory (e.g. a `reflet_ram16` instance) between two bus masters, such as a `reflet_cpu` and a DMA engine or a second core. Each requester holds a request until it receives a one-cycle acknowledge. The arbiter sequences each access through a fixed, parameterised number of memory wait cycles and returns read data on the acknowledge cycle. It sits between the masters' address/data buses and the memory's enable/addr/write_en ports, replacing ad-hoc address-bit enabling.

## Interface
- `wordsize`, 16, width of the data and address buses.
- `latency`, 1, memory read latency in cycles; legal range 1..15.
- `clk` in 1: system clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `req0`, `req1` in 1: access request. Held high, with the request's fields stable, until the matching ack.
- `addr0`, `addr1` in wordsize: request address.
- `wdata0`, `wdata1` in wordsize: write data.
- `we0`, `we1` in 1: 1 = write, 0 = read.
- `rdata0`, `rdata1` out wordsize: read data. Valid only while the matching ack is high, otherwise 0.
- `ack0`, `ack1` out 1: one-cycle completion pulse.
- `mem_enable` out 1: memory select.
- `mem_addr` out wordsize: memory address.
- `mem_data_out` out wordsize: memory write data.
- `mem_write_en` out 1: memory write strobe.
- `mem_data_in` in wordsize: memory read data.
- `busy` out 1: high while in ACCESS.
- `owner` out 1: index of the current or most recent grantee.

## Operation
- States:
  - IDLE: no access in flight.
  - ACCESS: access in flight, wait counter `cnt` (4 bits) running.
- Priority register `last` holds the last grantee. Reset value is 1, so master 0 wins first.
- IDLE behaviour:
  - If any req is high, pick the grantee `g`:
    - only one requester: that requester;
    - both requesting: the requester that is not `last`.
  - Combinationally drive `mem_enable` = 1, `mem_addr` = `addr_g`, `mem_data_out` = `wdata_g`, `mem_write_en` = `we_g` in that same cycle.
  - On the clock edge: `owner` ← g, `last` ← g, `cnt` ← latency−1, state ← ACCESS.
- ACCESS behaviour:
  - Keep driving the mem_* outputs from the owner's inputs, with `mem_write_en` forced to 0 so a write is issued exactly once.
  - While `cnt` ≠ 0: decrement `cnt`; no ack.
  - When `cnt` = 0:
    - `ack_owner` = 1;
    - `rdata_owner` = `mem_data_in` for reads, 0 for writes;
    - next state IDLE.
- Back-to-back accesses: a new grant can occur in the IDLE cycle immediately after an ack. Per-access occupancy is latency+1 cycles.
- All mem_* outputs are 0 in IDLE when no req is high.
- Both acks are never high together. ack never goes to a requester whose req was low at grant.
- A requester dropping req mid-ACCESS is a protocol violation. The access still completes and is acked; the ack is ignored.
- Reset, at any time including mid-ACCESS:
  - state ← IDLE, `last` ← 1, `owner` ← 0, `cnt` ← 0.
  - All outputs 0 in the cycle after the reset edge.
  - The in-flight access is abandoned with no ack.

## Timing
- Grant happens in cycle N, the IDLE cycle with req seen.
- Ack happens in cycle N+latency; `latency`=1 gives ack in N+1.
- `busy` is high during cycles N+1 .. N+latency.
- Outputs are registered-state decodes plus muxes. There is no combinational path from `mem_data_in` to anything except rdata.
- Fairness: with both requesters continuously active, grants strictly alternate, so worst-case wait is 2·(latency+1) cycles.

## Test plan
- Single read:
  - Stimulus: memory preloaded with 0xBEEF at 0x8010, latency=1; req0 read 0x8010 at cycle 5.
  - Required: mem_enable=1 and mem_addr=0x8010 in cycle 5; ack0=1 and rdata0=0xBEEF in cycle 6 only; ack1 stays 0.
- Write then read:
  - Stimulus: req1 writes 0x1234 to 0x8002, then reads 0x8002.
  - Required: mem_write_en high exactly one cycle; later read returns rdata1=0x1234.
- Simultaneous requests:
  - Stimulus: req0 and req1 both held from reset release for 8 cycles, latency=1.
  - Required: grant order 0,1,0,1; acks in cycles +1, +3, +5, +7 relative to the first grant; no double acks.
- Latency=3:
  - Stimulus: single read.
  - Required: ack exactly 3 cycles after grant; busy high for 3 cycles; mem_write_en never asserted for a read.
- Reset mid-ACCESS:
  - Stimulus: latency=3; assert reset one cycle after grant.
  - Required: no ack is issued; state is IDLE; all outputs are 0 in the cycle after reset; the next grant goes to master 0.
- Idle bus:
  - Stimulus: no requests for 20 cycles.
  - Required: mem_enable, mem_write_en, mem_addr and both acks stay 0.
